// File: rtl/skewed_adder_pkg.sv
// Shared math helpers for the chunk-pipelined arithmetic blocks.
package skewed_adder_pkg;

  // Number of chunks needed to cover num bits with den bits per chunk.
  function automatic int ceil_division(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Width of chunk k: every chunk is CHUNK bits except the top one,
  // which takes whatever is left of the word.
  function automatic int chunk_width(input int width, input int chunk, input int k);
    int n;
    n = ceil_division(width, chunk);
    if (k == n - 1) begin
      return width - (n - 1) * chunk;
    end
    return chunk;
  endfunction

endpackage

// File: rtl/shift_register.sv
// Enabled delay line of DEPTH stages; all stages clear on reset and hold
// while en_i is low.
module shift_register #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one position per enabled cycle; reset empties the whole line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/skewed_adder.sv
// Chunk-pipelined adder with skewed output: chunk k of a word's sum is
// registered k+1 enabled cycles after launch, and the carry ripples one
// chunk per cycle through registers. No valid gating on the data path;
// the downstream mask stage zeroes invalid words using out_valid.
module skewed_adder
  import skewed_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_carry
);

  localparam int N = ceil_division(WIDTH, CHUNK);

  // carry_w[k] is the registered carry out of stage k.
  logic [N-1:0] carry_w;
  logic         valid_q;
  logic         valid_d;

  assign valid_d = in_valid;

  // Word-valid flag, one enabled cycle behind the inputs (aligned with chunk 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_carry = carry_w[N-1];

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int CW = chunk_width(WIDTH, CHUNK, k);
    localparam int LO = k * CHUNK;

    logic [CW-1:0] a_k;
    logic [CW-1:0] b_k;
    logic          c_in;
    logic [CW:0]   sum_k;
    logic [CW-1:0] s_d;
    logic [CW-1:0] s_q;
    logic          c_d;
    logic          c_q;

    if (k == 0) begin : g_bypass
      // Chunk 0 adds the live operands with the live carry-in.
      assign a_k  = a[LO +: CW];
      assign b_k  = b[LO +: CW];
      assign c_in = cin;
    end else begin : g_delay
      // Delay chunk k by k enabled cycles so it meets the carry from stage k-1.
      logic [2*CW-1:0] dl_q;

      shift_register #(
        .DEPTH (k),
        .WIDTH (2 * CW)
      ) u_skew (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (en),
        .d_i   ({a[LO +: CW], b[LO +: CW]}),
        .q_o   (dl_q)
      );

      assign {a_k, b_k} = dl_q;
      assign c_in       = carry_w[k-1];
    end

    // One CW+1-bit add per stage; the top bit is the carry into the next chunk.
    assign sum_k = {1'b0, a_k} + {1'b0, b_k} + {{CW{1'b0}}, c_in};
    assign s_d   = sum_k[CW-1:0];
    assign c_d   = sum_k[CW];

    // Stage k sum and carry registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    assign out[LO +: CW] = s_q;
    assign carry_w[k]    = c_q;
  end

endmodule

// File: tb/tb_skewed_adder.sv
// Bench for skewed_adder: an 8-bit/2-bit-chunk instance checked by a
// word-level scoreboard plus directed checks, and a 7-bit/3-bit-chunk
// instance checked against a per-cycle expected table.
module tb_skewed_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  always #5 clk = ~clk;

  // DUT A: WIDTH=8, CHUNK=2 (N=4)
  logic [7:0] a8 = '0, b8 = '0, out8;
  logic       cin8 = 1'b0, v8 = 1'b0, ov8, oc8;

  // DUT B: WIDTH=7, CHUNK=3 (N=3, top chunk 1 bit)
  logic [6:0] a7 = '0, b7 = '0, out7;
  logic       cin7 = 1'b0, v7 = 1'b0, ov7, oc7;

  skewed_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8), .cin(cin8), .in_valid(v8),
    .out(out8), .out_valid(ov8), .out_carry(oc8)
  );

  skewed_adder #(.WIDTH(7), .CHUNK(3)) u_dut7 (
    .clk(clk), .rst(rst), .en(en), .a(a7), .b(b7), .cin(cin7), .in_valid(v7),
    .out(out7), .out_valid(ov7), .out_carry(oc7)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard (DUT A) ----------------
  // Expected word entry: {valid, carry, sum[7:0]}, tagged with the index of
  // the advancing edge that launched it.
  logic [9:0] exp_q[$];
  int         lidx_q[$];
  logic [7:0] snap_out [0:1023];
  logic       snap_c   [0:1023];
  logic       snap_v   [0:1023];
  int         ecount = 0;

  // One clock. Reset edges count as advancing edges that launch an all-zero
  // word and discard everything in flight.
  task automatic step();
    logic [8:0] s;
    logic [9:0] exp;
    logic [9:0] got;
    int         l;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      lidx_q.delete();
      exp_q.push_back(10'd0);
      lidx_q.push_back(ecount);
    end else if (en) begin
      s = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
      exp_q.push_back({v8, s});
      lidx_q.push_back(ecount);
    end
    #1;
    if (rst || en) begin
      snap_out[ecount] = out8;
      snap_c[ecount]   = oc8;
      snap_v[ecount]   = ov8;
      ecount++;
    end
    while (lidx_q.size() > 0 && lidx_q[0] + 3 < ecount) begin
      l   = lidx_q.pop_front();
      exp = exp_q.pop_front();
      got[1:0] = snap_out[l][1:0];
      got[3:2] = snap_out[l+1][3:2];
      got[5:4] = snap_out[l+2][5:4];
      got[7:6] = snap_out[l+3][7:6];
      got[8]   = snap_c[l+3];
      got[9]   = snap_v[l];
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sb_word launch=%0d got={v,c,sum}=%h exp=%h", l, got, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    a8 = a; b8 = b; cin8 = c; v8 = v;
  endtask

  task automatic drive7(input logic [6:0] a, input logic [6:0] b, input logic c, input logic v);
    a7 = a; b7 = b; cin7 = c; v7 = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    drive7(7'h00, 7'h00, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({out8, ov8, oc8} !== 10'd0) begin
        errors++;
        $display("FAIL reset8 cyc=%0d got out=%h v=%b c=%b exp 0", i, out8, ov8, oc8);
      end
      checks++;
      if ({out7, ov7, oc7} !== 9'd0) begin
        errors++;
        $display("FAIL reset7 cyc=%0d got out=%h v=%b c=%b exp 0", i, out7, ov7, oc7);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({out8, ov8, oc8} !== 10'd0) begin
        errors++;
        $display("FAIL idle_zero cyc=%0d got out=%h v=%b c=%b exp 0", i, out8, ov8, oc8);
      end
    end
  endtask

  task automatic test_ripple();
    logic exp_c [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_v [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    drive8(8'hFF, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      drive8(8'h00, 8'h00, 1'b0, 1'b0);
      checks++;
      if ({out8, ov8, oc8} !== {8'h00, exp_v[i], exp_c[i]}) begin
        errors++;
        $display("FAIL ripple E0+%0d got out=%h v=%b c=%b exp out=00 v=%b c=%b",
                 i, out8, ov8, oc8, exp_v[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive8(8'h12, 8'h34, 1'b0, 1'b1);
    step();
    drive8(8'hF0, 8'h0F, 1'b1, 1'b1);
    step();
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if (oc8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_carry0 got %b exp 0", oc8);
    end
    step();
    checks++;
    if (oc8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_carry1 got %b exp 1", oc8);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_en_gap();
    logic [7:0] exp_o [3] = '{8'h04, 8'h00, 8'h40};
    logic       exp_c [3] = '{1'b0, 1'b1, 1'b0};
    drive8(8'hFF, 8'h01, 1'b0, 1'b1);
    step();
    drive8(8'h12, 8'h34, 1'b0, 1'b1);
    step();
    en = 1'b0;
    drive8(8'hA5, 8'h5A, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out8, ov8, oc8} !== {8'h02, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL en_hold gap=%0d got out=%h v=%b c=%b exp out=02 v=1 c=0", i, out8, ov8, oc8);
      end
    end
    en = 1'b1;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out8, ov8, oc8} !== {exp_o[i], 1'b0, exp_c[i]}) begin
        errors++;
        $display("FAIL en_resume %0d got out=%h v=%b c=%b exp out=%h v=0 c=%b",
                 i, out8, ov8, oc8, exp_o[i], exp_c[i]);
      end
    end
    for (int i = 0; i < 2; i++) step();
  endtask

  task automatic test_reset_mid();
    drive8(8'hFF, 8'h01, 1'b0, 1'b1);
    step();
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    en  = 1'b1;
    step();
    checks++;
    if ({out8, ov8, oc8} !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset got out=%h v=%b c=%b exp 0", out8, ov8, oc8);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({out8, ov8, oc8} !== 10'd0) begin
        errors++;
        $display("FAIL no_stale cyc=%0d got out=%h v=%b c=%b exp 0", i, out8, ov8, oc8);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      en = ($urandom_range(0, 3) != 0);
      step();
    end
    en = 1'b1;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_w7();
    logic [6:0] exp_o [5] = '{7'h00, 7'h07, 7'h38, 7'h40, 7'h00};
    logic       exp_c [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_v [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    en = 1'b1;
    drive7(7'h7F, 7'h01, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) drive7(7'h40, 7'h3F, 1'b0, 1'b1);
      else        drive7(7'h00, 7'h00, 1'b0, 1'b0);
      checks++;
      if ({out7, oc7, ov7} !== {exp_o[i], exp_c[i], exp_v[i]}) begin
        errors++;
        $display("FAIL w7 E0+%0d got out=%h c=%b v=%b exp out=%h c=%b v=%b",
                 i, out7, oc7, ov7, exp_o[i], exp_c[i], exp_v[i]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_ripple();
    test_back_to_back();
    test_en_gap();
    test_reset_mid();
    test_random();
    test_w7();
    for (int i = 0; i < 4; i++) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
